// File: rtl/midori_mask_pkg.sv
// Shared constants and FSM encoding for the 3-share masked Midori nibble serializer.
package midori_mask_pkg;

    localparam int NIBBLE_W = 4;
    localparam int STATE_W  = 64;
    localparam int SHARES   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/masked_nibble_serializer_if.sv
// Bundle of the control, state and masked S-box signals of the serializer.
// master = host plus S-box side, slave = the serializer itself.
interface masked_nibble_serializer_if;
    import midori_mask_pkg::*;

    logic                load;
    logic                start;
    logic [STATE_W-1:0]  st_in1;
    logic [STATE_W-1:0]  st_in2;
    logic [STATE_W-1:0]  st_in3;
    logic [NIBBLE_W-1:0] sb_in1;
    logic [NIBBLE_W-1:0] sb_in2;
    logic [NIBBLE_W-1:0] sb_in3;
    logic [NIBBLE_W-1:0] sb_out1;
    logic [NIBBLE_W-1:0] sb_out2;
    logic [NIBBLE_W-1:0] sb_out3;
    logic [STATE_W-1:0]  st_out1;
    logic [STATE_W-1:0]  st_out2;
    logic [STATE_W-1:0]  st_out3;
    logic                busy;
    logic                done;

    modport master (
        output load, start, st_in1, st_in2, st_in3, sb_out1, sb_out2, sb_out3,
        input  sb_in1, sb_in2, sb_in3, st_out1, st_out2, st_out3, busy, done
    );

    modport slave (
        input  load, start, st_in1, st_in2, st_in3, sb_out1, sb_out2, sb_out3,
        output sb_in1, sb_in2, sb_in3, st_out1, st_out2, st_out3, busy, done
    );

endinterface

// File: rtl/masked_share_lane.sv
// One share's state register, its nibble read mux and its in-place write-back decoder.
// A lane only ever sees its own share; nothing here combines shares.
module masked_share_lane
    import midori_mask_pkg::*;
#(
    parameter int NIBBLES = 16,
    parameter int IDX_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [STATE_W-1:0]  i_st_in,
    input  logic                i_rd_en,
    input  logic [IDX_W-1:0]    i_rd_idx,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [NIBBLE_W-1:0] i_sb_out,
    output logic [NIBBLE_W-1:0] o_sb_in,
    output logic [STATE_W-1:0]  o_st
);

    logic [NIBBLES-1:0][NIBBLE_W-1:0] w_nibs;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            logic [NIBBLE_W-1:0] r_nib;

            // Nibble register: parallel load from the host, or S-box result written back in place
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_nib <= '0;
                end else if (i_load) begin
                    r_nib <= i_st_in[gi*NIBBLE_W +: NIBBLE_W];
                end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
                    r_nib <= i_sb_out;
                end
            end

            assign w_nibs[gi] = r_nib;
        end
    endgenerate

    assign o_st = w_nibs;

    // Read mux: selected nibble while streaming, zero otherwise so the S-box sees a quiet input
    always_comb begin
        o_sb_in = '0;
        if (i_rd_en) begin
            o_sb_in = w_nibs[i_rd_idx];
        end
    end

endmodule

// File: rtl/masked_nibble_serializer.sv
// Nibble-serial state controller for the 3-share masked Midori S-box pipeline.
// Streams nibble c of every share into the S-box and writes the result for nibble
// c-SBOX_LAT back in place; the FSM and counter are shared by the three lanes.
module masked_nibble_serializer
    import midori_mask_pkg::*;
#(
    parameter int NIBBLES  = 16,
    parameter int SBOX_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    masked_nibble_serializer_if.slave   bus
);

    localparam int TOTAL = NIBBLES + SBOX_LAT;
    localparam int CNT_W = $clog2(TOTAL);
    localparam int IDX_W = $clog2(NIBBLES);

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] NIB_C  = CNT_W'(NIBBLES);
    localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(SBOX_LAT);

    fsm_state_e         r_state;
    fsm_state_e         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_done;
    logic               w_done_next;

    logic               w_load_en;
    logic               w_rd_en;
    logic               w_wr_en;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [IDX_W-1:0]   w_wr_idx;

    // State register, pass counter and registered done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // Next state and counter: load wins over start, RUN walks the counter to its last value
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!bus.load && bus.start) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_C) begin
                    w_state_next = ST_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs decoded from state and count; done is registered so it lands one edge after DONE
    always_comb begin
        w_load_en   = (r_state == ST_IDLE) && bus.load;
        w_rd_en     = (r_state == ST_RUN) && (r_cnt < NIB_C);
        w_wr_en     = (r_state == ST_RUN) && (r_cnt >= LAT_C);
        w_rd_idx    = r_cnt[IDX_W-1:0];
        w_wr_idx    = IDX_W'(r_cnt - LAT_C);
        w_done_next = (r_state == ST_DONE);
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = r_done;

    logic [STATE_W-1:0]  w_st_in  [SHARES];
    logic [STATE_W-1:0]  w_st_out [SHARES];
    logic [NIBBLE_W-1:0] w_sb_out [SHARES];
    logic [NIBBLE_W-1:0] w_sb_in  [SHARES];

    assign w_st_in[0]  = bus.st_in1;
    assign w_st_in[1]  = bus.st_in2;
    assign w_st_in[2]  = bus.st_in3;
    assign w_sb_out[0] = bus.sb_out1;
    assign w_sb_out[1] = bus.sb_out2;
    assign w_sb_out[2] = bus.sb_out3;

    genvar gi;
    generate
        for (gi = 0; gi < SHARES; gi++) begin : g_lane
            masked_share_lane #(
                .NIBBLES (NIBBLES),
                .IDX_W   (IDX_W)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .i_load   (w_load_en),
                .i_st_in  (w_st_in[gi]),
                .i_rd_en  (w_rd_en),
                .i_rd_idx (w_rd_idx),
                .i_wr_en  (w_wr_en),
                .i_wr_idx (w_wr_idx),
                .i_sb_out (w_sb_out[gi]),
                .o_sb_in  (w_sb_in[gi]),
                .o_st     (w_st_out[gi])
            );
        end
    endgenerate

    assign bus.sb_in1  = w_sb_in[0];
    assign bus.sb_in2  = w_sb_in[1];
    assign bus.sb_in3  = w_sb_in[2];
    assign bus.st_out1 = w_st_out[0];
    assign bus.st_out2 = w_st_out[1];
    assign bus.st_out3 = w_st_out[2];

endmodule
